// File: rtl/uart_loopback_fifo.sv
// -----------------------------------------------------------------------------
// uart_loopback_fifo
//
// Byte buffer between the UART receiver and the UART transmitter of the
// loopback top level. Received bytes are written into a circular FIFO. A drain
// FSM launches one byte at a time into the transmitter and waits for the
// transmitter's busy handshake before it launches the next one.
//
// Optional feature (compile-time macro UART_FIFO_PARITY_DROP_EN):
//   defined   - bytes flagged with rx_parity_err_i are discarded, and the
//               extra output parity_drop_cnt_o counts them (saturating at 255)
//   undefined - rx_parity_err_i is ignored and the parity_drop_cnt_o port is
//               absent
//
// Ports:
//   clk               system clock
//   rst_n             synchronous active-low reset
//   rx_valid_i        one-cycle pulse: rx_data_i holds a received byte
//   rx_data_i         received byte
//   rx_parity_err_i   parity error for the current byte (qualified by rx_valid_i)
//   tx_busy_i         transmitter busy
//   clr_overflow_i    clears overflow_o (a drop in the same cycle wins)
//   tx_en_o           one-cycle launch pulse to the transmitter
//   tx_data_o         byte being launched, held until the next launch
//   count_o           current occupancy, 0..DEPTH
//   empty_o / full_o  occupancy flags (registered alongside count_o)
//   overflow_o        sticky: a byte was dropped because the FIFO was full
//   parity_drop_cnt_o number of parity-discarded bytes (feature builds only)
// -----------------------------------------------------------------------------
module uart_loopback_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_valid_i,
    input  logic [DATA_WIDTH-1:0]   rx_data_i,
    input  logic                    rx_parity_err_i,
    input  logic                    tx_busy_i,
    input  logic                    clr_overflow_i,
    output logic                    tx_en_o,
    output logic [DATA_WIDTH-1:0]   tx_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    overflow_o
`ifdef UART_FIFO_PARITY_DROP_EN
    ,
    output logic [7:0]              parity_drop_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_WAIT_FALL = 2'd3
    } state_t;

    state_t                  state_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic [AW-1:0]           wptr_r;
    logic [AW-1:0]           rptr_r;
    logic [CW-1:0]           count_r;
    logic                    empty_r;
    logic                    full_r;
    logic                    overflow_r;
    logic                    tx_en_r;
    logic [DATA_WIDTH-1:0]   tx_data_r;
    logic [TW-1:0]           timer_r;

    logic                    accept_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    drop_s;
    logic [CW-1:0]           count_nxt_s;

`ifdef UART_FIFO_PARITY_DROP_EN
    logic [7:0]              parity_cnt_r;

    // Bytes with a parity error never reach the FIFO.
    assign accept_s = rx_valid_i & ~rx_parity_err_i;
`else
    logic                    unused_parity_s;

    // Parity flag has no effect in this build; every valid byte is stored.
    assign accept_s        = rx_valid_i;
    assign unused_parity_s = rx_parity_err_i;
`endif

    // Push/pop decisions and next occupancy. A pop in the same cycle frees the
    // slot, so a push while full is still accepted when the FSM pops.
    always_comb begin
        pop_s  = (state_r == ST_IDLE) && !empty_r && !tx_busy_i;
        push_s = accept_s && (!full_r || pop_s);
        drop_s = accept_s && full_r && !pop_s;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage write; contents are intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_r[wptr_r] <= rx_data_i;
        end
    end

    // Write pointer, occupancy, flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r     <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {CW{1'b0}});
            full_r  <= (count_nxt_s == DEPTH_C);
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Drain FSM: pop, launch pulse, then wait for the busy handshake. The
    // launch pulse is registered on the IDLE->LAUNCH transition, so it is high
    // exactly while the FSM sits in LAUNCH and can never repeat back-to-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tx_en_r   <= 1'b0;
            tx_data_r <= {DATA_WIDTH{1'b0}};
            rptr_r    <= {AW{1'b0}};
            timer_r   <= {TW{1'b0}};
        end else begin
            tx_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tx_data_r <= mem_r[rptr_r];
                        rptr_r    <= rptr_r + AW'(1);
                        tx_en_r   <= 1'b1;
                        state_r   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    timer_r <= {TW{1'b0}};
                    state_r <= ST_WAIT_RISE;
                end
                ST_WAIT_RISE: begin
                    // If busy never rises, treat the byte as sent after
                    // BUSY_WAIT cycles in this state.
                    if (tx_busy_i) begin
                        state_r <= ST_WAIT_FALL;
                    end else if (timer_r == TIMER_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_WAIT_FALL: begin
                    if (!tx_busy_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_FIFO_PARITY_DROP_EN
    // Saturating count of parity-discarded bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_cnt_r <= 8'd0;
        end else if (rx_valid_i && rx_parity_err_i && (parity_cnt_r != 8'hFF)) begin
            parity_cnt_r <= parity_cnt_r + 8'd1;
        end
    end

    assign parity_drop_cnt_o = parity_cnt_r;
`endif

    assign tx_en_o    = tx_en_r;
    assign tx_data_o  = tx_data_r;
    assign count_o    = count_r;
    assign empty_o    = empty_r;
    assign full_o     = full_r;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_loopback_fifo
//
// Scoreboard bench for uart_loopback_fifo (DEPTH=16, DATA_WIDTH=8,
// BUSY_WAIT=4). Stimulus pushes expected transmitted bytes into exp_q and
// expected state samples into chk_q; a monitor on the falling clock edge pops
// and compares them.
// -----------------------------------------------------------------------------
module tb_uart_loopback_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int BW    = 4;

    // kinds of state sample the monitor can compare
    localparam int K_COUNT  = 0;
    localparam int K_EMPTY  = 1;
    localparam int K_FULL   = 2;
    localparam int K_OVF    = 3;
    localparam int K_PEND   = 4;
    localparam int K_PCNT   = 5;
    localparam int K_GAP    = 6;
    localparam int K_TXEN   = 7;
    localparam int K_TXDATA = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_parity_err;
    logic          busy_force;
    logic          model_busy;
    logic          model_en;
    logic          tx_busy;
    logic          clr_ovf;
    logic          tx_en;
    logic [DW-1:0] tx_data;
    logic [4:0]    count;
    logic          empty;
    logic          full;
    logic          overflow;
`ifdef UART_FIFO_PARITY_DROP_EN
    logic [7:0]    parity_cnt;
`endif

    typedef struct {
        string name;
        int    kind;
        int    val;
    } chk_t;

    chk_t          chk_q[$];
    logic [DW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            done   = 1'b0;

    assign tx_busy = busy_force | model_busy;

    always #5 clk = ~clk;

    uart_loopback_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .BUSY_WAIT  (BW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_valid_i        (rx_valid),
        .rx_data_i         (rx_data),
        .rx_parity_err_i   (rx_parity_err),
        .tx_busy_i         (tx_busy),
        .clr_overflow_i    (clr_ovf),
        .tx_en_o           (tx_en),
        .tx_data_o         (tx_data),
        .count_o           (count),
        .empty_o           (empty),
        .full_o            (full),
        .overflow_o        (overflow)
`ifdef UART_FIFO_PARITY_DROP_EN
        ,
        .parity_drop_cnt_o (parity_cnt)
`endif
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic want(input string name, input int kind, input int val);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.val  = val;
        chk_q.push_back(c);
    endtask

    // One-cycle receive pulse; 'stored' says whether the byte must come out.
    task automatic send(input logic [DW-1:0] b, input logic perr, input bit stored);
        rx_valid      = 1'b1;
        rx_data       = b;
        rx_parity_err = perr;
        if (stored) begin
            exp_q.push_back(b);
        end
        tick(1);
        rx_valid      = 1'b0;
        rx_parity_err = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        want("drained", K_PEND, 0);
    endtask

    // Transmitter model: busy rises one cycle after a launch and stays high
    // for 100 cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (model_en && tx_en) begin
                @(posedge clk);
                #1;
                model_busy = 1'b1;
                repeat (100) begin
                    @(posedge clk);
                    #1;
                end
                model_busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int          cyc;
        int          last_en;
        int          gap;
        bit          prev_en;
        bit          prev_busy;
        logic [7:0]  e;
        chk_t        c;
        logic [31:0] act;
        cyc       = 0;
        last_en   = -100;
        gap       = 0;
        prev_en   = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_en === 1'b1) begin
                checks++;
                if (prev_en || prev_busy) begin
                    errors++;
                    $display("FAIL launch_spacing: en_prev=%0b busy_prev=%0b, required both 0",
                             prev_en, prev_busy);
                end
                gap     = cyc - last_en;
                last_en = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx: launched 0x%02h, required no launch", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got 0x%02h, required 0x%02h", tx_data, e);
                    end
                end
            end
            prev_en   = (tx_en === 1'b1);
            prev_busy = (tx_busy === 1'b1);
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                case (c.kind)
                    K_COUNT:  act = 32'(count);
                    K_EMPTY:  act = {31'd0, empty};
                    K_FULL:   act = {31'd0, full};
                    K_OVF:    act = {31'd0, overflow};
                    K_PEND:   act = 32'(exp_q.size());
                    K_GAP:    act = 32'(gap);
                    K_TXEN:   act = {31'd0, tx_en};
                    K_TXDATA: act = 32'(tx_data);
`ifdef UART_FIFO_PARITY_DROP_EN
                    K_PCNT:   act = 32'(parity_cnt);
`endif
                    default:  act = 32'hFFFF_FFFF;
                endcase
                checks++;
                if (act !== 32'(c.val)) begin
                    errors++;
                    $display("FAIL %s: got %0d, required %0d", c.name, act, c.val);
                end
            end
            if (done) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, required completion within time limit");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        rst_n         = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;
        rx_parity_err = 1'b0;
        busy_force    = 1'b0;
        clr_ovf       = 1'b0;
        model_en      = 1'b0;
        tick(2);
        want("rst_count", K_COUNT, 0);
        want("rst_empty", K_EMPTY, 1);
        want("rst_full", K_FULL, 0);
        want("rst_ovf", K_OVF, 0);
        want("rst_txen", K_TXEN, 0);
        want("rst_txdata", K_TXDATA, 0);
        rst_n = 1'b1;
        tick(1);

        // Single byte: launch two cycles after the receive pulse.
        send(8'h5A, 1'b0, 1'b1);
        want("single_count_up", K_COUNT, 1);
        tick(1);
        want("single_launch", K_TXEN, 1);
        want("single_count_down", K_COUNT, 0);
        tick(8);

        // Busy handshake with the transmitter model.
        model_en = 1'b1;
        send(8'h01, 1'b0, 1'b1);
        send(8'h02, 1'b0, 1'b1);
        send(8'h03, 1'b0, 1'b1);
        wait_drain(600);
        tick(110);
        model_en = 1'b0;

        // Overflow: 18 bytes while busy, the last two are lost.
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(8'(i), 1'b0, (i < DEPTH));
        end
        want("ovf_count", K_COUNT, 16);
        want("ovf_full", K_FULL, 1);
        want("ovf_empty", K_EMPTY, 0);
        want("ovf_flag", K_OVF, 1);
        busy_force = 1'b0;
        wait_drain(400);
        tick(8);
        want("ovf_drain_count", K_COUNT, 0);
        want("ovf_drain_empty", K_EMPTY, 1);
        want("ovf_sticky", K_OVF, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        want("ovf_cleared", K_OVF, 0);

        // Simultaneous push and pop while full, across the pointer wrap.
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send(8'h20 + 8'(i), 1'b0, 1'b1);
        end
        want("wrap_full", K_FULL, 1);
        busy_force = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(8'h30 + 8'(k), 1'b0, 1'b1);
            want("simul_count", K_COUNT, 16);
            want("simul_full", K_FULL, 1);
            want("simul_ovf", K_OVF, 0);
            tick(5);
        end
        wait_drain(400);
        tick(8);

        // Busy never rises: launches spaced BUSY_WAIT+2 cycles.
        send(8'h40, 1'b0, 1'b1);
        send(8'h41, 1'b0, 1'b1);
        wait_drain(100);
        want("timeout_gap", K_GAP, BW + 2);
        tick(8);

        // Clear alongside a drop: set wins; a clear alone then clears.
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send(8'h50 + 8'(i), 1'b0, 1'b1);
        end
        clr_ovf = 1'b1;
        send(8'h60, 1'b0, 1'b0);
        clr_ovf = 1'b0;
        want("clr_set_wins", K_OVF, 1);
        want("clr_drop_count", K_COUNT, 16);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        want("clr_alone", K_OVF, 0);
        busy_force = 1'b0;
        wait_drain(300);
        tick(8);

`ifdef UART_FIFO_PARITY_DROP_EN
        // Parity-flagged bytes are discarded and counted.
        send(8'h80, 1'b1, 1'b0);
        send(8'h81, 1'b0, 1'b1);
        send(8'h82, 1'b1, 1'b0);
        want("parity_cnt", K_PCNT, 2);
        wait_drain(50);
        want("parity_no_ovf", K_OVF, 0);
        tick(8);
`endif

        // Reset during WAIT_FALL with five bytes still queued.
        model_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(8'h70 + 8'(i), 1'b0, 1'b1);
        end
        tick(3);
        want("pre_reset_count", K_COUNT, 5);
        rst_n = 1'b0;
        exp_q.delete();
        tick(1);
        rst_n = 1'b1;
        want("mid_rst_count", K_COUNT, 0);
        want("mid_rst_empty", K_EMPTY, 1);
        want("mid_rst_txen", K_TXEN, 0);
        tick(150);
        want("mid_rst_idle_empty", K_EMPTY, 1);
        model_en = 1'b0;
        tick(2);
        done = 1'b1;
    end

endmodule
